// File: rtl/mem_loader.sv
// Byte-stream memory loader: takes a length byte and N data bytes, writes them to memory
// from address 0, then releases the processor. Optional checksum path: LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic             mem_en,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_writedata,
    output logic             cpu_reset,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_FLUSH,
        S_RUN
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CSUM,
        S_ERR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] adr_q, adr_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] wr_adr_q, wr_adr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             in_ready_q, in_ready_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             done_q, done_d;
    logic             accept;
    logic             last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             err_q, err_d;
`endif

    assign accept    = in_valid && in_ready_q;
    assign last_byte = (adr_q == len_q - WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        len_d     = len_q;
        wr_d      = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d = in_data;
                    adr_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = in_data;
                    state_d = (in_data != '0) ? S_LOAD : S_CSUM;
`else
                    state_d = (in_data != '0) ? S_LOAD : S_RUN;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_d      = 1'b1;
                    wr_adr_d  = adr_q;
                    wr_data_d = in_data;
                    adr_d     = adr_q + WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data;
                    if (last_byte) state_d = S_CSUM;
`else
                    if (last_byte) state_d = S_FLUSH;
`endif
                end
            end
            // FLUSH is the cycle in which the final registered write is on the port
            S_FLUSH: state_d = S_RUN;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
            end
`endif
            default: state_d = state_q;
        endcase

        in_ready_d  = (state_d == S_LEN) || (state_d == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                      || (state_d == S_CSUM)
`endif
                      ;
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
`ifdef LOADER_CHECKSUM_EN
        err_d       = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LEN;
            adr_q       <= '0;
            len_q       <= '0;
            wr_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            err_q       <= err_d;
`endif
        end
        wr_adr_q  <= wr_adr_d;
        wr_data_q <= wr_data_d;
    end

    // The processor owns the memory port only once it has been released
    assign mem_en        = 1'b1;
    assign mem_write     = (state_q == S_RUN) ? cpu_memwrite  : wr_q;
    assign mem_adr       = (state_q == S_RUN) ? cpu_adr       : wr_adr_q;
    assign mem_writedata = (state_q == S_RUN) ? cpu_writedata : wr_data_q;
    assign in_ready      = in_ready_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: scoreboard of expected memory writes, immediate-assert checks.
module tb_mem_loader;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] adr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             cpu_memwrite = 1'b0;
    logic [WIDTH-1:0] cpu_adr = '0;
    logic [WIDTH-1:0] cpu_writedata = '0;
    logic             mem_en;
    logic             mem_write;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_writedata;
    logic             cpu_reset;
    logic             done;
    logic             err;

    int checks = 0;
    int failures = 0;
    wr_t exp_q[$];
    logic [WIDTH-1:0] model_adr;
    logic [WIDTH-1:0] model_sum;

    mem_loader #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_adr(mem_adr), .mem_writedata(mem_writedata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one edge; returns #1 after that edge.
    task automatic drive(input logic [WIDTH-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_len(input logic [WIDTH-1:0] n);
        model_adr = '0;
        model_sum = n;
        drive(n);
        chk("len_no_write", {31'b0, mem_write}, 32'd0);
    endtask

    task automatic send_data(input logic [WIDTH-1:0] d);
        wr_t e;
        exp_q.push_back('{adr: model_adr, data: d});
        model_adr = model_adr + 8'd1;
        model_sum = model_sum + d;
        drive(d);
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("wr_pulse", {31'b0, mem_write}, 32'd1);
            chk("wr_adr", {24'b0, mem_adr}, {24'b0, e.adr});
            chk("wr_data", {24'b0, mem_writedata}, {24'b0, e.data});
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hEE;
        @(posedge clk);
        #1;
        chk("gap_no_write", {31'b0, mem_write}, 32'd0);
    endtask

    // Called right after the last data write is visible on the port.
    task automatic finish_stream();
        chk("held_during_last_write", {31'b0, cpu_reset}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
        drive(model_sum);
`else
        @(posedge clk);
        #1;
`endif
        chk("run_done", {31'b0, done}, 32'd1);
        chk("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        chk("run_no_write", {31'b0, mem_write}, 32'd0);
        chk("run_in_ready", {31'b0, in_ready}, 32'd0);
        chk("run_err", {31'b0, err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back three-byte load
        send_len(8'h03);
        send_data(8'hA1);
        send_data(8'hB2);
        send_data(8'hC3);
        finish_stream();

        // Processor owns the memory port in RUN
        @(negedge clk);
        cpu_memwrite  = 1'b1;
        cpu_adr       = 8'h40;
        cpu_writedata = 8'h5A;
        #1;
        chk("cpu_pass_write", {31'b0, mem_write}, 32'd1);
        chk("cpu_pass_adr", {24'b0, mem_adr}, 32'h40);
        chk("cpu_pass_data", {24'b0, mem_writedata}, 32'h5A);
        cpu_memwrite = 1'b0;
        #1;
        chk("cpu_pass_idle", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("run_ignores_valid_ready", {31'b0, in_ready}, 32'd0);
        chk("run_ignores_valid_done", {31'b0, done}, 32'd1);
        chk("run_ignores_valid_write", {31'b0, mem_write}, 32'd0);

        // Zero-length image
        do_reset();
        send_len(8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("len0_wait_csum", {31'b0, in_ready}, 32'd1);
        chk("len0_not_done", {31'b0, done}, 32'd0);
        drive(8'h00);
`endif
        chk("len0_done", {31'b0, done}, 32'd1);
        chk("len0_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        chk("len0_no_write", {31'b0, mem_write}, 32'd0);

        // Gaps in in_valid
        do_reset();
        send_len(8'h03);
        send_data(8'h11);
        idle_cycle();
        idle_cycle();
        send_data(8'h22);
        idle_cycle();
        send_data(8'h33);
        finish_stream();

        // Reset mid-load, then a fresh stream
        do_reset();
        send_len(8'h04);
        send_data(8'h01);
        send_data(8'h02);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrst_no_write", {31'b0, mem_write}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_len(8'h01);
        send_data(8'h77);
        finish_stream();

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksums
        do_reset();
        send_len(8'h02);
        send_data(8'h10);
        send_data(8'h20);
        chk("csum_model", {24'b0, model_sum}, 32'h32);
        finish_stream();
        do_reset();
        send_len(8'h02);
        send_data(8'h10);
        send_data(8'h20);
        drive(8'h33);
        chk("csum_bad_err", {31'b0, err}, 32'd1);
        chk("csum_bad_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("csum_bad_done", {31'b0, done}, 32'd0);
        chk("csum_bad_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("csum_err_held", {31'b0, err}, 32'd1);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data, address and length width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  WIDTH  byte-stream data.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have ports cpu_memwrite (input, 1), cpu_adr (input, WIDTH) and cpu_writedata (input, WIDTH), carrying the processor memory requests.
REQ-008 SHALL have ports mem_en (output, 1), mem_write (output, 1), mem_adr (output, WIDTH) and mem_writedata (output, WIDTH), forming the memory port.
REQ-009 SHALL have port cpu_reset  output  1  active-high reset to the processor.
REQ-010 SHALL have port done  output  1  load complete and processor running.
REQ-011 SHALL have port err  output  1  checksum failure; present only with LOADER_CHECKSUM_EN, see REQ-026.

Function
REQ-012 SHALL implement states LEN, LOAD, FLUSH, CSUM, RUN and ERR; CSUM and ERR exist only with LOADER_CHECKSUM_EN.
REQ-013 SHALL accept a byte on a rising edge exactly when in_valid and in_ready are both high; in_ready SHALL be 1 in LEN, LOAD and CSUM and 0 otherwise.
REQ-014 SHALL, in LEN, store the accepted byte as count N and clear the address counter.
- N != 0: go to LOAD.
- N == 0: go to CSUM if checksum is enabled, else go to RUN.
REQ-015 SHALL, for each byte accepted in LOAD, drive mem_write=1, mem_adr=address and mem_writedata=byte for exactly one cycle, starting the cycle after acceptance (1-cycle latency, registered), then increment the address.
REQ-016 SHALL, on acceptance of byte N, go to CSUM if checksum is enabled, else to FLUSH; FLUSH SHALL last one cycle (the final write) and then go to RUN.
REQ-017 SHALL, while in_valid is low, hold state and address with mem_write=0; idle gaps of any length are legal.
REQ-018 SHALL write addresses 0..N-1 only; the address never wraps because N <= 2^WIDTH-1.
REQ-019 SHALL, in every state except RUN, drive the memory port from the loader and ignore the cpu_* inputs; in RUN, mem_write, mem_adr and mem_writedata SHALL equal cpu_memwrite, cpu_adr and cpu_writedata combinationally.
REQ-020 SHALL hold mem_en at 1 in all states.
REQ-021 SHALL drive cpu_reset=1 in every state except RUN, and 0 in RUN.
REQ-022 SHALL drive done=1 only in RUN; RUN and ERR SHALL be held until reset.
REQ-023 SHALL, in RUN, ignore in_valid; in_ready SHALL stay 0.

Reset
REQ-024 SHALL, on reset high at a clock edge, enter LEN and set:
- address=0, N=0, checksum accumulator=0;
- mem_write=0, in_ready=1, cpu_reset=1, done=0, err=0.
REQ-025 SHALL honour reset mid-load: any pending write is dropped (mem_write=0 the next cycle) and already-written memory is left untouched.

Configuration
REQ-026 SHALL compile checksum support in only when LOADER_CHECKSUM_EN is defined, with this behaviour:
- accumulator = length byte plus every data byte, modulo 2^WIDTH;
- in CSUM, the next accepted byte is compared with the accumulator;
- equal: go to RUN;
- unequal: go to ERR, with err=1, cpu_reset=1 and done=0;
- the final data write still occurs in the first CSUM cycle.
REQ-027 SHALL, without LOADER_CHECKSUM_EN, have no CSUM or ERR logic, tie err to 0, and take the LOAD->FLUSH->RUN path.

Verification
REQ-028 SHALL verify: stream 0x03,0xA1,0xB2,0xC3 back-to-back -> writes (0x00,0xA1),(0x01,0xB2),(0x02,0xC3) on consecutive cycles; RUN and cpu_reset=0 the cycle after the last write; done=1.
REQ-029 SHALL verify: length 0x00, checksum disabled -> RUN on the next edge, no mem_write pulse.
REQ-030 SHALL verify: in_valid toggled 1,0,0,1 during the data bytes -> exactly one write per accepted byte, no duplicate write during gaps.
REQ-031 SHALL verify: with LOADER_CHECKSUM_EN, stream 0x02,0x10,0x20,0x32 -> RUN, err=0; with the last byte 0x33 instead -> ERR, err=1, cpu_reset stays 1.
REQ-032 SHALL verify: in RUN, cpu_memwrite=1, cpu_adr=0x40, cpu_writedata=0x5A -> mem_write=1, mem_adr=0x40, mem_writedata=0x5A in the same cycle.
REQ-033 SHALL verify: reset asserted after the second of four data bytes -> LEN, mem_write=0 next cycle, cpu_reset=1; a fresh stream 0x01,0x77 then writes 0x77 to address 0x00.
